ext_feeder: RTL and testbench



---
 rtl/ext_feeder.sv | 174 +++++++++++++++++
 tb/tb_ext_feeder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_feeder.sv
// ext_feeder: buffers host bytes in a small FIFO and hands them one at a time
// to the pico core's external input pins. Each byte gets an INT_W-cycle
// interrupt pulse, is held until the core acks, and is followed by an
// interrupt-low gap so the core's rising-edge detector sees every byte.
module ext_feeder #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int INT_W = 2,
  parameter int GAP_W = 2
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic [N-1:0]             host_data_i,
  input  logic                     host_valid_i,
  output logic                     host_ready_o,
  output logic [N-1:0]             ext_data_o,
  output logic                     ext_int_o,
  input  logic                     ack_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (INT_W > GAP_W) ? INT_W : GAP_W;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] INT_LOAD = TW'(INT_W - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_W - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            ack_seen_q, ack_seen_d;
  logic            int_q, int_d;
  logic [N-1:0]    data_q, data_d;
  logic            busy_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    mem_q [DEPTH];
  logic            push_s, pop_s;

  // No bypass: ready depends only on the registered occupancy.
  assign host_ready_o = (count_q != FULL);
  assign push_s       = host_valid_i && host_ready_o;

  assign ext_data_o = data_q;
  assign ext_int_o  = int_q;
  assign count_o    = count_q;
  assign busy_o     = busy_q;

  // FIFO storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= host_data_i;
    end
  end

  // Occupancy update: a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Handshake FSM: load byte, pulse interrupt, wait for ack, enforce low gap.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    ack_seen_d = ack_seen_q;
    int_d      = int_q;
    data_d     = data_q;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        int_d = 1'b0;
        if (count_q != {CW{1'b0}}) begin
          data_d  = mem_q[rd_ptr_q];
          pop_s   = 1'b1;
          tmr_d   = INT_LOAD;
          int_d   = 1'b1;
          state_d = ASSERT;
        end else begin
          state_d = IDLE;
        end
      end
      ASSERT: begin
        int_d      = 1'b1;
        ack_seen_d = ack_seen_q | ack_i;
        if (tmr_q == {TW{1'b0}}) begin
          int_d = 1'b0;
          tmr_d = GAP_LOAD;
          if (ack_seen_q || ack_i) begin
            state_d = GAP;
          end else begin
            state_d = WAIT_ACK;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      WAIT_ACK: begin
        int_d = 1'b0;
        if (ack_i) begin
          tmr_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      GAP: begin
        int_d = 1'b0;
        if (tmr_q == {TW{1'b0}}) begin
          ack_seen_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        int_d      = 1'b0;
        ack_seen_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // FSM state, timer, presented byte and interrupt registers.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= IDLE;
      tmr_q      <= {TW{1'b0}};
      ack_seen_q <= 1'b0;
      int_q      <= 1'b0;
      data_q     <= {N{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      ack_seen_q <= ack_seen_d;
      int_q      <= int_d;
      data_q     <= data_d;
      busy_q     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ext_feeder.sv
// Scoreboard bench for ext_feeder: stimulus queues the expected presented
// bytes (and, where fixed, the rise-to-rise period); a negedge monitor checks
// each interrupt pulse against that queue.
module tb_ext_feeder;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int INT_W = 2;
  localparam int GAP_W = 2;

  logic         clk_i = 1'b0;
  logic         n_rst_i = 1'b1;
  logic [N-1:0] host_data_i = 8'h00;
  logic         host_valid_i = 1'b0;
  logic         host_ready_o;
  logic [N-1:0] ext_data_o;
  logic         ext_int_o;
  logic         ack_i = 1'b0;
  logic [2:0]   count_o;
  logic         busy_o;

  ext_feeder #(.N(N), .DEPTH(DEPTH), .INT_W(INT_W), .GAP_W(GAP_W)) dut (
    .clk_i        (clk_i),
    .n_rst_i      (n_rst_i),
    .host_data_i  (host_data_i),
    .host_valid_i (host_valid_i),
    .host_ready_o (host_ready_o),
    .ext_data_o   (ext_data_o),
    .ext_int_o    (ext_int_o),
    .ack_i        (ack_i),
    .count_o      (count_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    int         per;   // expected cycles since previous rise; 0 = unchecked
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         last_rise = 0;
  int         high_cnt = 0;
  logic       prev_int = 1'b0;
  logic [7:0] hold = 8'h00;

  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (!n_rst_i) begin
      prev_int = 1'b0;
      high_cnt = 0;
    end else begin
      if (ext_int_o && !prev_int) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", 32'(ext_data_o), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_data", 32'(ext_data_o), 32'(e.data));
          if (e.per != 0) chk("rise_period", cyc - last_rise, e.per);
        end
        last_rise = cyc;
        hold      = ext_data_o;
        high_cnt  = 1;
      end else if (ext_int_o) begin
        high_cnt++;
        chk("data_stable", 32'(ext_data_o), 32'(hold));
      end else if (prev_int) begin
        chk("pulse_width", high_cnt, INT_W);
      end
      prev_int = ext_int_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input int per);
    int guard = 0;
    exp_t e;
    @(negedge clk_i);
    host_data_i  = d;
    host_valid_i = 1'b1;
    while (!host_ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 200) begin
      chk("push_timeout", 0, 1);
    end
    e.data = d;
    e.per  = per;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    host_valid_i = 1'b0;
  endtask

  task automatic wait_int(input logic lvl);
    int guard = 0;
    while (ext_int_o !== lvl && guard < 50) begin
      tick(1);
      guard++;
    end
    if (guard >= 50) chk("wait_int_timeout", 32'(ext_int_o), 32'(lvl));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(host_ready_o), 1);
    chk({tag, "_count"}, 32'(count_o), 0);
    chk({tag, "_int"},   32'(ext_int_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_data"},  32'(ext_data_o), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // 1: asynchronous reset takes effect without a clock edge
    #2 n_rst_i = 1'b0;
    #1 chk_reset_vals("rst_async");
    #19 n_rst_i = 1'b1;
    tick(2);
    chk_reset_vals("rst_idle");

    // 2: single byte, late ack
    push(8'h5A, 0);
    chk("t2_count_after_push", 32'(count_o), 1);
    tick(1);
    chk("t2_int_after_load", 32'(ext_int_o), 1);
    chk("t2_data_after_load", 32'(ext_data_o), 32'h5A);
    chk("t2_count_after_pop", 32'(count_o), 0);
    tick(2);
    chk("t2_int_low_wait", 32'(ext_int_o), 0);
    chk("t2_busy_wait", 32'(busy_o), 1);
    tick(2);
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    chk("t2_busy_gap1", 32'(busy_o), 1);
    tick(1);
    chk("t2_busy_gap2", 32'(busy_o), 1);
    tick(1);
    chk("t2_busy_idle", 32'(busy_o), 0);
    chk("t2_data_held", 32'(ext_data_o), 32'h5A);
    chk("t2_int_idle", 32'(ext_int_o), 0);

    // 3: ordering with ack held high
    ack_i = 1'b1;
    push(8'h11, 0);
    push(8'h22, INT_W + GAP_W + 1);
    push(8'h33, INT_W + GAP_W + 1);
    tick(20);
    ack_i = 1'b0;
    chk("t3_drain", sb_q.size(), 0);
    chk("t3_busy", 32'(busy_o), 0);

    // 4: full FIFO, back-pressure, release by ack
    push(8'h41, 0);
    tick(4);
    chk("t4_busy_wait", 32'(busy_o), 1);
    chk("t4_count0", 32'(count_o), 0);
    fork
      begin
        push(8'h42, 0);
        push(8'h43, 0);
        push(8'h44, 0);
        push(8'h45, 0);
        push(8'h46, 0);
      end
      begin
        int guard = 0;
        while (count_o != 3'd4 && guard < 50) begin
          tick(1);
          guard++;
        end
        chk("t4_full_count", 32'(count_o), 4);
        chk("t4_full_ready", 32'(host_ready_o), 0);
        tick(3);
        chk("t4_hold_count", 32'(count_o), 4);
        chk("t4_hold_ready", 32'(host_ready_o), 0);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        tick(2);
        chk("t4_gap_count", 32'(count_o), 4);
        tick(1);
        chk("t4_pop_count", 32'(count_o), 3);
        chk("t4_pop_ready", 32'(host_ready_o), 1);
        tick(1);
        chk("t4_refill_count", 32'(count_o), 4);
      end
    join
    ack_i = 1'b1;
    tick(40);
    ack_i = 1'b0;
    chk("t4_drain", sb_q.size(), 0);
    chk("t4_count_end", 32'(count_o), 0);

    // 5: early ack in first ASSERT cycle only
    fork
      begin
        push(8'h71, 0);
        push(8'h72, INT_W + GAP_W + 1);
        push(8'h73, INT_W + GAP_W + 1);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          wait_int(1'b0);
          wait_int(1'b1);
          ack_i = 1'b1;
          tick(1);
          ack_i = 1'b0;
        end
      end
    join
    tick(8);
    chk("t5_drain", sb_q.size(), 0);
    chk("t5_busy", 32'(busy_o), 0);

    // 6: reset mid-ASSERT with two bytes queued
    push(8'h81, 0);
    push(8'h82, 0);
    push(8'h83, 0);
    chk("t6_int_before", 32'(ext_int_o), 1);
    chk("t6_count_before", 32'(count_o), 2);
    #2 n_rst_i = 1'b0;
    #1 chk_reset_vals("t6_rst");
    sb_q.delete();
    #4 n_rst_i = 1'b1;
    tick(10);
    chk("t6_no_stale_int", 32'(ext_int_o), 0);
    chk("t6_no_stale_busy", 32'(busy_o), 0);
    chk("t6_no_stale_count", 32'(count_o), 0);
    ack_i = 1'b1;
    push(8'h99, 0);
    tick(8);
    ack_i = 1'b0;
    chk("t6_new_byte", 32'(ext_data_o), 32'h99);
    chk("t6_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
